// File: rtl/alu_sweep_pkg.sv
// alu_sweep_pkg: shared types for the ALU sweep sequencer.
// Code index maps to (S,M) with M in the LSB.
package alu_sweep_pkg;

  localparam int NUM_CODES = 32;
  localparam int IDX_W     = 5;
  localparam int CNT_W     = 4;
  localparam int RES_W     = 16;

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_CODES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
  } tag_t;

  typedef struct packed {
    logic [3:0]       s;
    logic             m;
    logic [RES_W-1:0] f;
  } result_t;

  function automatic tag_t idx2tag(
    input logic [IDX_W-1:0] i
  );
    tag_t t;
    t.s = i[4:1];
    t.m = i[0];
    return t;
  endfunction

endpackage

// File: rtl/alu_sweep_buffer.sv
// alu_sweep_buffer: 32-entry result store, one sync write
// port filled during capture, one comb read port for drain.
module alu_sweep_buffer
  import alu_sweep_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [NUM_CODES];
  logic [WIDTH-1:0] mem_d [NUM_CODES];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_sweep_sequencer.sv
// alu_sweep_sequencer: drives an external ALU through all
// 32 (S,M) codes for one operand pair, then streams results.
module alu_sweep_sequencer
  import alu_sweep_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_m,
  output logic [3:0]       alu_s,
  input  logic [WIDTH-1:0] alu_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic [3:0]       out_s,
  output logic             out_m,
  output logic             out_last,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD =
    CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  // SETTLE covers the HOLD extra cycles; CAPTURE is the
  // final cycle of each code, so a code lasts HOLD+1.
  localparam state_e CODE_START =
    (HOLD == '0) ? CAPTURE : SETTLE;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rd_q, rd_d;
  logic [IDX_W-1:0] idx_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  tag_t             tag_q, tag_d;
  logic             in_fire;
  logic             out_fire;
  logic             buf_we;
  logic [WIDTH-1:0] rd_data;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign idx_inc  = idx_q + IDX_W'(1);
  assign buf_we   = (state_q == CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) state_d = CODE_START;
      end
      SETTLE: begin
        if (cnt_q <= ONE) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (idx_q == LAST_IDX) state_d = DRAIN;
        else                   state_d = CODE_START;
      end
      DRAIN: begin
        if (out_fire && rd_q == LAST_IDX)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    tag_d = tag_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          a_d   = in_a;
          b_d   = in_b;
          idx_d = '0;
          tag_d = '0;
          cnt_d = HOLD;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - ONE;
      end
      CAPTURE: begin
        if (idx_q == LAST_IDX) begin
          rd_d = '0;
        end else begin
          idx_d = idx_inc;
          tag_d = idx2tag(idx_inc);
          cnt_d = HOLD;
        end
      end
      DRAIN: begin
        if (out_fire) rd_d = rd_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DRAIN);
    alu_a     = a_q;
    alu_b     = b_q;
    alu_s     = tag_q.s;
    alu_m     = tag_q.m;
    out_f     = '0;
    out_s     = '0;
    out_m     = 1'b0;
    out_last  = 1'b0;
    if (state_q == DRAIN) begin
      out_f    = rd_data;
      out_s    = rd_q[4:1];
      out_m    = rd_q[0];
      out_last = (rd_q == LAST_IDX);
    end
  end

  alu_sweep_buffer #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (alu_f),
    .raddr (rd_q),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_alu_sweep_sequencer.sv
// tb_alu_sweep_sequencer: sequencer with a behavioural 74181
// ALU plus two stub-ALU instances at HOLD_CYCLES 0 and 3.
module tb_alu_sweep_sequencer;

  localparam int MAIN_H   = 1;
  localparam int MAIN_LAT = 32 * (MAIN_H + 1) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic [15:0] alu_a, alu_b, alu_f, out_f;
  logic [3:0]  alu_s, out_s;
  logic        alu_m, out_valid, out_m, out_last, busy;

  logic        s_iv [2];
  logic        s_in_ready [2];
  logic [15:0] s_alu_a [2];
  logic [15:0] s_alu_b [2];
  logic        s_alu_m [2];
  logic [3:0]  s_alu_s [2];
  logic [15:0] s_alu_f [2];
  logic        s_out_valid [2];
  logic [15:0] s_out_f [2];
  logic [3:0]  s_out_s [2];
  logic        s_out_m [2];
  logic        s_out_last [2];
  logic        s_busy [2];

  always #5 clk = ~clk;

  // 74181 active-high function table, carry-in inactive
  function automatic logic [15:0] alu181(
    input logic [15:0] a, input logic [15:0] b,
    input logic [3:0] s, input logic m);
    logic [15:0] r;
    if (m) begin
      case (s)
        4'd0:  r = ~a;
        4'd1:  r = ~(a | b);
        4'd2:  r = ~a & b;
        4'd3:  r = 16'h0000;
        4'd4:  r = ~(a & b);
        4'd5:  r = ~b;
        4'd6:  r = a ^ b;
        4'd7:  r = a & ~b;
        4'd8:  r = ~a | b;
        4'd9:  r = ~(a ^ b);
        4'd10: r = b;
        4'd11: r = a & b;
        4'd12: r = 16'hFFFF;
        4'd13: r = a | ~b;
        4'd14: r = a | b;
        default: r = a;
      endcase
    end else begin
      case (s)
        4'd0:  r = a;
        4'd1:  r = a | b;
        4'd2:  r = a | ~b;
        4'd3:  r = 16'hFFFF;
        4'd4:  r = a + (a & ~b);
        4'd5:  r = (a | b) + (a & ~b);
        4'd6:  r = a - b - 16'd1;
        4'd7:  r = (a & ~b) - 16'd1;
        4'd8:  r = a + (a & b);
        4'd9:  r = a + b;
        4'd10: r = (a | ~b) + (a & b);
        4'd11: r = (a & b) - 16'd1;
        4'd12: r = a + a;
        4'd13: r = (a | b) + a;
        4'd14: r = (a | ~b) + a;
        default: r = a - 16'd1;
      endcase
    end
    return r;
  endfunction

  assign alu_f = alu181(alu_a, alu_b, alu_s, alu_m);

  alu_sweep_sequencer #(
    .WIDTH(16), .HOLD_CYCLES(MAIN_H)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_m(alu_m), .alu_s(alu_s), .alu_f(alu_f),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_s(out_s), .out_m(out_m),
    .out_last(out_last), .busy(busy)
  );

  for (genvar k = 0; k < 2; k++) begin : g_stub
    localparam int H = (k == 0) ? 0 : 3;
    assign s_alu_f[k] = s_alu_a[k] ^
      {11'b0, s_alu_s[k], s_alu_m[k]};
    alu_sweep_sequencer #(
      .WIDTH(16), .HOLD_CYCLES(H)
    ) u_stub (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_iv[k]), .in_ready(s_in_ready[k]),
      .in_a(in_a), .in_b(in_b),
      .alu_a(s_alu_a[k]), .alu_b(s_alu_b[k]),
      .alu_m(s_alu_m[k]), .alu_s(s_alu_s[k]),
      .alu_f(s_alu_f[k]),
      .out_valid(s_out_valid[k]), .out_ready(1'b1),
      .out_f(s_out_f[k]), .out_s(s_out_s[k]),
      .out_m(s_out_m[k]), .out_last(s_out_last[k]),
      .busy(s_busy[k])
    );
  end

  typedef struct {
    logic [15:0] f;
    logic [3:0]  s;
    logic        m;
    logic        last;
  } rec_t;

  rec_t        q[$];
  bit          active = 0;
  bit          first_seen = 0;
  bit          bp_mode = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          got_n = 0;
  int          jobs_done = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] got [32];

  function automatic void chk(input string nm,
    input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
        nm, act, exp);
    end
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (bp_mode) begin
      #1 out_ready = ($urandom_range(0, 9) < 3);
    end
  end

  // Scoreboard: a job is 32 records, produced in code order
  // and presented MAIN_LAT cycles after the accept cycle.
  always @(negedge clk) begin
    bit   was_active;
    bit   exp_valid;
    rec_t r;
    if (rst_n) begin
      was_active = active;
      exp_valid = active &&
        (first_seen || (cyc - acc_cyc) >= MAIN_LAT);
      chk("busy", busy, active);
      chk("in_ready", in_ready, !active);
      chk("out_valid", out_valid, exp_valid);
      if (out_valid && q.size() > 0) begin
        first_seen = 1;
        r = q[0];
        chk("out_f", out_f, r.f);
        chk("out_tag", {out_s, out_m}, {r.s, r.m});
        chk("out_last", out_last, r.last);
        if (out_ready) begin
          if (got_n < 32) got[got_n] = out_f;
          got_n++;
          if (r.last) begin
            active = 0;
            jobs_done++;
          end
          void'(q.pop_front());
        end
      end
      if (!was_active && in_valid) begin
        for (int i = 0; i < 32; i++) begin
          r.s = 4'(i >> 1);
          r.m = 1'(i & 1);
          r.f = alu181(in_a, in_b, r.s, r.m);
          r.last = (i == 31);
          q.push_back(r);
        end
        active = 1;
        first_seen = 0;
        acc_cyc = cyc;
        got_n = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_f", out_f, 0);
    chk("rst_out_tag", {out_s, out_m}, 0);
    chk("rst_alu_ab", {alu_a, alu_b}, 0);
    chk("rst_alu_sm", {alu_s, alu_m}, 0);
    q.delete();
    active = 0;
    first_seen = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [15:0] a,
                      input logic [15:0] b);
    int n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((active || busy) && n < bound);
    chk("idle", {active, busy}, 0);
  endtask

  task automatic stub_run(input int k, input int h,
                          input logic [15:0] a);
    int n = 0;
    @(posedge clk);
    #1;
    s_iv[k] = 1'b1;
    in_a = a;
    in_b = ~a;
    @(negedge clk);
    chk("stub_in_ready", s_in_ready[k], 1);
    @(posedge clk);
    #1 s_iv[k] = 1'b0;
    while (!s_out_valid[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("stub_latency", n, 32 * (h + 1) + 1);
    for (int i = 0; i < 32; i++) begin
      chk("stub_f", s_out_f[k], a ^ 16'(i));
      chk("stub_tag", {s_out_s[k], s_out_m[k]}, i);
      chk("stub_last", s_out_last[k], (i == 31));
      @(negedge clk);
    end
    chk("stub_done", {s_out_valid[k], s_busy[k]}, 0);
  endtask

  initial begin
    int j0;
    int n;
    s_iv[0] = 1'b0;
    s_iv[1] = 1'b0;
    #3;
    do_reset();

    // directed operands with hand-derived logic results
    send(16'h5309, 16'h9546);
    wait_idle(400);
    chk("pin_s0m1", got[1], 16'hACF6);
    chk("pin_s11m1", got[23], 16'h1100);
    chk("pin_s6m1", got[13], 16'hC64F);
    chk("pin_s15m1", got[31], 16'h5309);
    chk("pin_s9m0", got[18], 16'hE84F);

    stub_run(0, 0, 16'h1234);
    stub_run(1, 3, 16'hBEEF);

    bp_mode = 1;
    send(16'hC0DE, 16'h0F1E);
    wait_idle(3000);
    bp_mode = 0;
    @(posedge clk);
    #1 out_ready = 1'b1;

    // in_valid held high with changing operands
    j0 = jobs_done;
    n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a = 16'h1111;
    in_b = 16'h2222;
    while (jobs_done == j0 && n < 400) begin
      @(posedge clk);
      #1;
      in_a = in_a + 16'h0101;
      in_b = in_b ^ 16'h00FF;
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle(400);

    send(16'hA5A5, 16'h5A5A);
    repeat (19) @(posedge clk);
    do_reset();
    send(16'h7E57, 16'h0042);
    wait_idle(400);

    send(16'h0F0F, 16'h3C3C);
    n = 0;
    while (!(active && got_n == 10) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_rd10", got_n, 10);
    do_reset();
    send(16'h8001, 16'h7FFE);
    wait_idle(400);

    send(16'hFFFF, 16'h0001);
    send(16'h0000, 16'h0000);
    wait_idle(400);
    chk("b2b_zero_s0m0", got[0], 16'h0000);
    chk("b2b_zero_s3m0", got[6], 16'hFFFF);

    chk("queue_empty", q.size(), 0);
    chk("jobs_done", jobs_done, 8);
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
